// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Holds the requester count, index width, FSM state type and the
// round-robin winner search used by the top level.
package rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Scan pointer, pointer+1, ... (mod NUM_REQ) and return the first set request.
    // Returns the pointer itself when no request is set; callers only use the
    // result when at least one request is present.
    function automatic logic [IDX_W-1:0] next_rr_index(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   pointer
    );
        logic [IDX_W-1:0] cand;
        logic             found;
        next_rr_index = pointer;
        found         = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = pointer + k[IDX_W-1:0];
            if (!found && req[cand]) begin
                next_rr_index = cand;
                found         = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/grant_decoder_2_4.sv
// Combinational 2-to-4 one-hot decoder with enable.
// Drives the arbiter's grant bus; the parent registers its output.
module grant_decoder_2_4
    import rr_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   index_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    // Decode the index to a one-hot vector, all zero when not enabled.
    always_comb begin
        onehot_o = 4'b0000;
        if (enable_i) begin
            case (index_i)
                2'd0:    onehot_o = 4'b0001;
                2'd1:    onehot_o = 4'b0010;
                2'd2:    onehot_o = 4'b0100;
                2'd3:    onehot_o = 4'b1000;
                default: onehot_o = 4'b0000;
            endcase
        end else begin
            onehot_o = 4'b0000;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter_4.sv
// Round-robin arbiter sharing one resource among 4 requesters.
// A grant is held until the owner asserts Done_In, drops its request or
// (when built with RR_ARB_TIMEOUT_EN defined) holds it for MAX_HOLD_CYCLES
// cycles. Every release is followed by one dead GAP cycle.
// All outputs are registered copies of the current FSM view, so they trail
// the state register by one cycle.
module rr_decoder_arbiter_4
    import rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD_CYCLES = 16
) (
    input  logic               Clock_In,
    input  logic               Reset_In,
    input  logic               Enable_In,
    input  logic [NUM_REQ-1:0] Request_In,
    input  logic               Done_In,
    output logic [NUM_REQ-1:0] Grant_Out,
    output logic [IDX_W-1:0]   Grant_Index_Out,
    output logic               Grant_Valid_Out,
    output logic               Timeout_Out,
    output logic               Busy_Out
);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;

    logic               owner_req_s;
    logic               timeout_hit_s;
    logic               forced_s;
    logic               release_s;
    logic               in_grant_s;
    logic               timeout_pulse_s;
    logic [NUM_REQ-1:0] dec_grant_s;

    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   index_q;
    logic               valid_q;
    logic               timeout_q;
    logic               busy_q;

    assign in_grant_s  = (state_q == GRANT);
    assign owner_req_s = Request_In[owner_q];
    assign release_s   = Done_In | ~owner_req_s | timeout_hit_s;
    // A timeout only counts as forced when nothing else ended the grant.
    assign forced_s    = timeout_hit_s & ~Done_In & owner_req_s;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD_CYCLES + 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             to_flag_q, to_flag_d;

    assign timeout_hit_s   = in_grant_s && (hold_cnt_q == CNT_W'(MAX_HOLD_CYCLES - 1));
    assign timeout_pulse_s = (state_q == GAP) && to_flag_q;

    // Count cycles spent in GRANT and remember whether the release was forced.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        to_flag_d  = 1'b0;
        if (in_grant_s) begin
            if (release_s) begin
                hold_cnt_d = '0;
                to_flag_d  = forced_s;
            end else begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                to_flag_d  = 1'b0;
            end
        end else begin
            hold_cnt_d = '0;
            to_flag_d  = 1'b0;
        end
    end

    // Hold counter and forced-release flag registers.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            hold_cnt_q <= '0;
            to_flag_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            to_flag_q  <= to_flag_d;
        end
    end
`else
    assign timeout_hit_s   = 1'b0;
    assign timeout_pulse_s = 1'b0;
`endif

    // Next-state, pointer and owner selection.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE, GAP: begin
                // GAP arbitrates exactly like IDLE, using the pointer updated on release.
                if (Enable_In && (|Request_In)) begin
                    state_d = GRANT;
                    owner_d = next_rr_index(Request_In, ptr_q);
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_d = GAP;
                    ptr_d   = owner_q + 2'd1;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 2'd0;
                owner_d = 2'd0;
            end
        endcase
    end

    // FSM state, round-robin pointer and current/last owner registers.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    grant_decoder_2_4 u_grant_decoder (
        .index_i  (owner_q),
        .enable_i (in_grant_s),
        .onehot_o (dec_grant_s)
    );

    // Register the externally visible view of the FSM.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            grant_q   <= 4'b0000;
            index_q   <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            grant_q   <= dec_grant_s;
            index_q   <= owner_q;
            valid_q   <= in_grant_s;
            timeout_q <= timeout_pulse_s;
            busy_q    <= in_grant_s;
        end
    end

    assign Grant_Out       = grant_q;
    assign Grant_Index_Out = index_q;
    assign Grant_Valid_Out = valid_q;
    assign Timeout_Out     = timeout_q;
    assign Busy_Out        = busy_q;

endmodule
